// File: rtl/fsm_seq_pkg.sv
// Shared constants and types for the fsm_seq step sequencer.
// Holds the IDLE code, the default parameter values and the per-cycle action type.
// No ports. Imported by fsm_seq and fsm_seq_next.
package fsm_seq_pkg;

  localparam int IDLE_CODE   = 0;
  localparam int N_STEPS_DEF = 7;
  localparam int STATE_W_DEF = 3;
  localparam int DWELL_W_DEF = 8;

  // What the sequencer does on the coming edge.
  typedef enum logic [1:0] {
    ACT_STAY  = 2'd0,  // remain in the current code (idle, dwelling or held)
    ACT_START = 2'd1,  // leave IDLE into the first unskipped step
    ACT_ADV   = 2'd2,  // dwell expired and not held: move on
    ACT_ABORT = 2'd3   // drop to IDLE without a done pulse
  } seq_act_t;

endpackage

// File: rtl/fsm_seq_next.sv
// Next-step finder: lowest unskipped step code strictly above cur (cur=0 means "any").
// Ports: cur (current code), skip_mask, loop_en -> nxt (next code), pass_end (no step above cur).
// Purely combinational; when the pass ends nxt wraps to the first unskipped step if loop_en, else IDLE.
module fsm_seq_next
  import fsm_seq_pkg::*;
#(
  parameter int N_STEPS = N_STEPS_DEF,
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic [STATE_W-1:0] cur,
  input  logic [N_STEPS-1:0] skip_mask,
  input  logic               loop_en,
  output logic [STATE_W-1:0] nxt,
  output logic               pass_end
);

  logic [STATE_W-1:0] above;
  logic [STATE_W-1:0] first;

  // Scanning downwards leaves the lowest qualifying index in each result.
  always_comb begin
    above = STATE_W'(IDLE_CODE);
    first = STATE_W'(IDLE_CODE);
    for (int k = N_STEPS; k >= 1; k--) begin
      if (!skip_mask[k-1]) begin
        first = STATE_W'(k);
        if (STATE_W'(k) > cur) above = STATE_W'(k);
      end
    end
  end

  always_comb begin
    pass_end = (above == STATE_W'(IDLE_CODE));
    if (!pass_end)    nxt = above;
    else if (loop_en) nxt = first;
    else              nxt = STATE_W'(IDLE_CODE);
  end

endmodule

// File: rtl/fsm_seq.sv
// Step sequencer: IDLE (zot=0) then steps 1..N_STEPS with per-step dwell, hold, skip and loop.
// Ports: clk, reset (sync, active-low), start, abort, loop_en, skip_mask, hold_mask, dwell
//        -> zot (registered step code), busy (zot!=0), done (registered one-cycle end-of-pass pulse).
module fsm_seq
  import fsm_seq_pkg::*;
#(
  parameter int N_STEPS = N_STEPS_DEF,
  parameter int STATE_W = STATE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic [N_STEPS-1:0] skip_mask,
  input  logic [N_STEPS-1:0] hold_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [STATE_W-1:0] zot,
  output logic               busy,
  output logic               done
);

  localparam logic [STATE_W-1:0] IDLE = STATE_W'(IDLE_CODE);

  logic [STATE_W-1:0] zot_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [DWELL_W-1:0] cap, cap_nxt;
  logic               done_nxt;
  logic [STATE_W-1:0] nx_code;
  logic               nx_end;
  logic               hold_cur;
  seq_act_t           act;

  // From IDLE, cur=0 makes the finder return the lowest unskipped step,
  // so one instance serves both the start and the advance decision.
  fsm_seq_next #(
    .N_STEPS (N_STEPS),
    .STATE_W (STATE_W)
  ) u_next (
    .cur       (zot),
    .skip_mask (skip_mask),
    .loop_en   (loop_en),
    .nxt       (nx_code),
    .pass_end  (nx_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      zot  <= IDLE;
      cnt  <= '0;
      cap  <= '0;
      done <= 1'b0;
    end else begin
      zot  <= zot_nxt;
      cnt  <= cnt_nxt;
      cap  <= cap_nxt;
      done <= done_nxt;
    end
  end

  // hold bit of the step currently occupied; zero in IDLE
  always_comb begin
    hold_cur = 1'b0;
    for (int k = 1; k <= N_STEPS; k++) begin
      if (zot == STATE_W'(k)) hold_cur = hold_mask[k-1];
    end
  end

  // cnt only climbs to cap while busy, so equality marks dwell expiry and
  // doubles as saturation while a held step waits.
  always_comb begin
    act = ACT_STAY;
    if (zot == IDLE) begin
      if (start && !abort) act = ACT_START;
    end else if (abort) begin
      act = ACT_ABORT;
    end else if ((cnt == cap) && !hold_cur) begin
      act = ACT_ADV;
    end
  end

  always_comb begin
    zot_nxt  = zot;
    cnt_nxt  = cnt;
    cap_nxt  = cap;
    done_nxt = 1'b0;
    case (act)
      ACT_START: begin
        // all-skipped start: nx_code is IDLE and nx_end gives the lone done pulse
        zot_nxt  = nx_code;
        done_nxt = nx_end;
        cap_nxt  = dwell;
        cnt_nxt  = '0;
      end
      ACT_ADV: begin
        zot_nxt  = nx_code;
        done_nxt = nx_end;
        cnt_nxt  = '0;
      end
      ACT_ABORT: begin
        zot_nxt = IDLE;
        cnt_nxt = '0;
      end
      default: begin
        if ((zot != IDLE) && (cnt != cap)) cnt_nxt = cnt + 1'b1;
      end
    endcase
  end

  assign busy = (zot != IDLE);

endmodule
